pipeline_trap_controller: RTL and testbench
===========================================

# pipeline_trap_controller

Parametrised hazard and trap controller for the in-order core. It generates per-stage stall and flush vectors from stage stall requests, branch mispredictions and exceptions. It arbitrates exceptions and machine-mode interrupts into a single registered trap report for the CSR unit, then holds the front end flushed until the CSR unit acknowledges the redirect. It sits between all pipeline stages and the CSR/trap unit.

## Interface
- NUM_STAGES, 5: pipeline depth; stage 0 = fetch, stage NUM_STAGES-1 = writeback (oldest).
- XLEN, 32: PC width.
- BRANCH_STAGE, 2: stage that resolves branches; a misprediction flushes stages 0..BRANCH_STAGE-1.
- CAUSE_W, 5: trap cause width; bit CAUSE_W-1 = interrupt flag, bits [3:0] = code.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_req_i  in  NUM_STAGES  per-stage stall request.
- flush_branch_i  in  1  misprediction resolved in BRANCH_STAGE.
- exc_valid_i  in  NUM_STAGES  per-stage exception flag.
- exc_cause_i  in  NUM_STAGES*4  per-stage exception code, stage k at [4k+3:4k].
- exc_pc_i  in  NUM_STAGES*XLEN  per-stage PC, stage k at [XLEN*k+XLEN-1:XLEN*k].
- irq_i  in  3  {external, timer, software} pending.
- irq_enable_i  in  3  per-source enable, already ANDed with mstatus.MIE.
- commit_pc_i  in  XLEN  PC of the oldest valid instruction; used as EPC for interrupts.
- redirect_ack_i  in  1  CSR unit has driven the trap vector into fetch.
- stall_o  out  NUM_STAGES  per-stage stall.
- flush_o  out  NUM_STAGES  per-stage flush.
- trap_valid_o  out  1  one-cycle registered trap pulse.
- trap_cause_o  out  CAUSE_W  registered trap cause.
- trap_pc_o  out  XLEN  registered EPC.
- busy_o  out  1  FSM not in IDLE.

## Operation
- Stall propagation (combinational): stall_o[k] = OR of stall_req_i[j] for j >= k, then forced to 0 wherever flush_o[k] = 1.
- Exception selection happens in IDLE only. The oldest stage k with exc_valid_i[k] = 1 and stall_req_i[NUM_STAGES-1:k+1] = 0 wins. An exception in a stage below BRANCH_STAGE while flush_branch_i = 1 is wrong-path and is discarded.
- Interrupt selection happens in IDLE only, when no exception is accepted and stall_req_i = 0. Masked pending = irq_i & irq_enable_i.
  - Priority: external (code 11) > software (code 3) > timer (code 7).
  - Cause MSB = 1; EPC = commit_pc_i.
- FSM states:
  - IDLE: flush_o = branch flush vector (stages 0..BRANCH_STAGE-1 if flush_branch_i). On an accepted trap, flush_o[0..k] = 1 in that same cycle (all stages for an interrupt), cause and PC are latched, and the FSM goes to TRAP.
  - TRAP (1 cycle): trap_valid_o = 1; flush_o = all ones; next state WAIT.
  - WAIT: flush_o = all ones. On redirect_ack_i, go to IDLE next cycle; exc/irq inputs are ignored.
- busy_o = (state != IDLE).

## Timing
- Reset (rst_i = 0, asynchronous): state IDLE, trap_valid_o = 0, trap_cause_o = 0, trap_pc_o = 0, busy_o = 0. flush_o = all ones while reset is asserted.
- Trap detected in cycle N: flush asserted in cycle N; trap_valid_o, cause and PC are valid in cycle N+1; WAIT begins at N+2.
- redirect_ack_i arriving in TRAP is ignored; only an ack in WAIT counts. After an ack in cycle M, IDLE begins at M+1 and a new trap may be taken at M+1.
- trap_cause_o and trap_pc_o hold their values until the next trap.
- Reset asserted mid-trap returns the FSM to IDLE immediately; no pulse is issued.

## Configuration
- PIPECTRL_IRQ_EN:
  - Defined: interrupt selection as above.
  - Undefined: irq_i, irq_enable_i and commit_pc_i are ignored, interrupts are never taken, and the cause MSB is always 0.

## Test plan
- Stall back-pressure: stall_req_i = 5'b00100 -> stall_o = 5'b00111, flush_o = 0, no trap.
- Branch flush: flush_branch_i = 1 with exc_valid_i = 5'b00001 -> flush_o = 5'b00011, exception dropped, busy_o stays 0.
- Exception priority: exc_valid_i = 5'b01010, stage 3 cause 4, PC 0x100 -> flush_o = 5'b01111 at N; trap_valid_o at N+1 with cause 0x04, trap_pc_o = 0x100; busy_o until one cycle after redirect_ack_i.
- Interrupt arbitration: irq_i = 3'b111, irq_enable_i = 3'b011, commit_pc_i = 0x2000 -> cause 0x13 (software), trap_pc_o = 0x2000. Rerun without PIPECTRL_IRQ_EN -> no trap.
- Events during trap: exc_valid_i pulses in WAIT -> ignored. Ack in TRAP -> not honoured; ack in WAIT -> IDLE next cycle.
- Reset mid-WAIT: drop rst_i -> busy_o = 0 and flush_o = all ones immediately; trap_valid_o = 0.

Source files
------------

// File: rtl/pipeline_trap_controller_if.sv
// pipeline_trap_controller_if
// Bundles the signals between the pipeline stages, the CSR/trap unit and the
// hazard/trap controller.
//   slave  : controller side (requests in, stall/flush/trap report out)
//   master : pipeline + CSR side (drives requests, observes stall/flush/trap)
// Stage k of the packed per-stage buses sits at [4k+3:4k] for exc_cause_i and
// at [XLEN*k+XLEN-1:XLEN*k] for exc_pc_i.
interface pipeline_trap_controller_if #(
  parameter int NUM_STAGES = 5,
  parameter int XLEN       = 32,
  parameter int CAUSE_W    = 5
);
  logic [NUM_STAGES-1:0]      stall_req_i;
  logic                       flush_branch_i;
  logic [NUM_STAGES-1:0]      exc_valid_i;
  logic [NUM_STAGES*4-1:0]    exc_cause_i;
  logic [NUM_STAGES*XLEN-1:0] exc_pc_i;
  logic [2:0]                 irq_i;
  logic [2:0]                 irq_enable_i;
  logic [XLEN-1:0]            commit_pc_i;
  logic                       redirect_ack_i;
  logic [NUM_STAGES-1:0]      stall_o;
  logic [NUM_STAGES-1:0]      flush_o;
  logic                       trap_valid_o;
  logic [CAUSE_W-1:0]         trap_cause_o;
  logic [XLEN-1:0]            trap_pc_o;
  logic                       busy_o;

  modport slave (
    input  stall_req_i, flush_branch_i, exc_valid_i, exc_cause_i, exc_pc_i,
           irq_i, irq_enable_i, commit_pc_i, redirect_ack_i,
    output stall_o, flush_o, trap_valid_o, trap_cause_o, trap_pc_o, busy_o
  );

  modport master (
    output stall_req_i, flush_branch_i, exc_valid_i, exc_cause_i, exc_pc_i,
           irq_i, irq_enable_i, commit_pc_i, redirect_ack_i,
    input  stall_o, flush_o, trap_valid_o, trap_cause_o, trap_pc_o, busy_o
  );
endinterface

// File: rtl/pipeline_trap_controller.sv
// pipeline_trap_controller
// Hazard and trap controller for the in-order core. Produces per-stage stall
// and flush vectors, picks the oldest eligible exception (or a machine-mode
// interrupt), reports it to the CSR unit as a registered one-cycle pulse and
// keeps the front end flushed until the CSR unit acknowledges the redirect.
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - pipeline_trap_controller_if.slave (requests, stall/flush, trap report)
// Build option: PIPECTRL_IRQ_EN enables interrupt selection; without it the
// interrupt inputs are ignored and the cause MSB is always 0.
//
// state | meaning
// IDLE  | normal operation, exception/interrupt selection active
// TRAP  | one cycle, trap_valid_o asserted, full flush
// WAIT  | full flush until redirect_ack_i
module pipeline_trap_controller #(
  parameter int NUM_STAGES   = 5,
  parameter int XLEN         = 32,
  parameter int BRANCH_STAGE = 2,
  parameter int CAUSE_W      = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  pipeline_trap_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [NUM_STAGES-1:0] ALL_ONES = {NUM_STAGES{1'b1}};

  state_t state, state_nxt;

  logic [NUM_STAGES-1:0] branch_vec;
  logic                  exc_take;
  logic [NUM_STAGES-1:0] exc_mask;
  logic [3:0]            exc_code;
  logic [XLEN-1:0]       exc_pc;
  logic                  irq_take;
  logic [3:0]            irq_code;
  logic [NUM_STAGES-1:0] flush_nxt;
  logic                  load;
  logic [CAUSE_W-1:0]    load_cause;
  logic [XLEN-1:0]       load_pc;
  logic [CAUSE_W-1:0]    cause_q;
  logic [XLEN-1:0]       pc_q;

  always_comb begin
    branch_vec = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      branch_vec[k] = bus.flush_branch_i && (k < BRANCH_STAGE);
    end
  end

  // Scan from the youngest stage upward so the oldest eligible stage is the
  // last one written and wins. A stall in any older stage holds the exception
  // back, since the instructions ahead of it have not retired yet.
  always_comb begin
    exc_take = 1'b0;
    exc_mask = '0;
    exc_code = '0;
    exc_pc   = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (bus.exc_valid_i[k] &&
          ((bus.stall_req_i >> (k + 1)) == '0) &&
          !(bus.flush_branch_i && (k < BRANCH_STAGE))) begin
        exc_take = 1'b1;
        exc_mask = ALL_ONES >> (NUM_STAGES - 1 - k);
        exc_code = bus.exc_cause_i[4*k +: 4];
        exc_pc   = bus.exc_pc_i[XLEN*k +: XLEN];
      end
    end
  end

`ifdef PIPECTRL_IRQ_EN
  logic [2:0] irq_masked;

  assign irq_masked = bus.irq_i & bus.irq_enable_i;

  // irq bits are {external, timer, software}; software outranks timer.
  always_comb begin
    irq_code = 4'd0;
    if (irq_masked[2])      irq_code = 4'd11;
    else if (irq_masked[0]) irq_code = 4'd3;
    else if (irq_masked[1]) irq_code = 4'd7;
  end

  assign irq_take = !exc_take && (bus.stall_req_i == '0) && (irq_masked != 3'b000);
`else
  logic unused_irq;

  assign unused_irq = ^{bus.irq_i, bus.irq_enable_i, bus.commit_pc_i};
  assign irq_code   = 4'd0;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    flush_nxt  = ALL_ONES;
    load       = 1'b0;
    load_cause = '0;
    load_pc    = '0;
    case (state)
      ST_IDLE: begin
        flush_nxt = branch_vec;
        if (exc_take) begin
          flush_nxt           = branch_vec | exc_mask;
          load                = 1'b1;
          load_cause[3:0]     = exc_code;
          load_pc             = exc_pc;
          state_nxt           = ST_TRAP;
        end else if (irq_take) begin
          flush_nxt           = ALL_ONES;
          load                = 1'b1;
          load_cause[3:0]     = irq_code;
          load_cause[CAUSE_W-1] = 1'b1;
`ifdef PIPECTRL_IRQ_EN
          load_pc             = bus.commit_pc_i;
`endif
          state_nxt           = ST_TRAP;
        end
      end
      ST_TRAP: state_nxt = ST_WAIT;
      ST_WAIT: if (bus.redirect_ack_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cause_q <= load_cause;
        pc_q    <= load_pc;
      end
    end
  end

  // The whole pipe is held flushed while reset is low.
  assign bus.flush_o = rst_i ? flush_nxt : ALL_ONES;

  always_comb begin
    logic acc;
    acc = 1'b0;
    bus.stall_o = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      acc = acc | bus.stall_req_i[k];
      bus.stall_o[k] = acc & ~bus.flush_o[k];
    end
  end

  assign bus.trap_valid_o = (state == ST_TRAP);
  assign bus.trap_cause_o = cause_q;
  assign bus.trap_pc_o    = pc_q;
  assign bus.busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_pipeline_trap_controller.sv
module tb_pipeline_trap_controller;
  localparam int N  = 5;
  localparam int XL = 32;
  localparam int BS = 2;
  localparam int CW = 5;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // reference model: phase 0 = idle, 1 = reporting, 2 = waiting for ack
  int          m_phase = 0;
  logic [CW-1:0] m_cause = '0;
  logic [XL-1:0] m_pc = '0;

  pipeline_trap_controller_if #(.NUM_STAGES(N), .XLEN(XL), .CAUSE_W(CW)) bus ();

  pipeline_trap_controller #(
    .NUM_STAGES(N), .XLEN(XL), .BRANCH_STAGE(BS), .CAUSE_W(CW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall_req_i    = '0;
    bus.flush_branch_i = 1'b0;
    bus.exc_valid_i    = '0;
    bus.exc_cause_i    = '0;
    bus.exc_pc_i       = '0;
    bus.irq_i          = '0;
    bus.irq_enable_i   = '0;
    bus.commit_pc_i    = '0;
    bus.redirect_ack_i = 1'b0;
  endtask

  // Model of what the controller should do this cycle, from current inputs.
  task automatic model(output logic [N-1:0] e_flush, output logic [N-1:0] e_stall,
                       output bit take, output logic [CW-1:0] t_cause,
                       output logic [XL-1:0] t_pc);
    int win;
    take = 0; t_cause = '0; t_pc = '0; win = -1;
    if (m_phase != 0) begin
      e_flush = '1;
    end else begin
      e_flush = bus.flush_branch_i ? N'((1 << BS) - 1) : '0;
      for (int k = N - 1; k >= 0 && win < 0; k--) begin
        if (bus.exc_valid_i[k] && (int'(bus.stall_req_i) >> (k + 1)) == 0 &&
            !(bus.flush_branch_i && k < BS))
          win = k;
      end
      if (win >= 0) begin
        take = 1;
        e_flush = e_flush | N'((1 << (win + 1)) - 1);
        t_cause = CW'((bus.exc_cause_i >> (4 * win)) & 4'hf);
        t_pc    = XL'(bus.exc_pc_i >> (XL * win));
      end
`ifdef PIPECTRL_IRQ_EN
      else if (bus.stall_req_i == 0 && (bus.irq_i & bus.irq_enable_i) != 0) begin
        logic [2:0] p;
        p = bus.irq_i & bus.irq_enable_i;
        take = 1;
        e_flush = '1;
        t_cause = CW'(1 << (CW - 1)) | CW'(p[2] ? 11 : (p[0] ? 3 : 7));
        t_pc = bus.commit_pc_i;
      end
`endif
    end
    for (int k = 0; k < N; k++)
      e_stall[k] = ((int'(bus.stall_req_i) >> k) != 0) && !e_flush[k];
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one clock.
  task automatic cycle();
    logic [N-1:0] ef, es;
    bit tk;
    logic [CW-1:0] tc;
    logic [XL-1:0] tp;
    #1;
    model(ef, es, tk, tc, tp);
    chk("flush", 64'(bus.flush_o), 64'(ef));
    chk("stall", 64'(bus.stall_o), 64'(es));
    chk("busy", 64'(bus.busy_o), 64'(m_phase != 0));
    chk("trap_valid", 64'(bus.trap_valid_o), 64'(m_phase == 1));
    chk("trap_cause", 64'(bus.trap_cause_o), 64'(m_cause));
    chk("trap_pc", 64'(bus.trap_pc_o), 64'(m_pc));
    @(posedge clk_i);
    case (m_phase)
      0: if (tk) begin m_phase = 1; m_cause = tc; m_pc = tp; end
      1: m_phase = 2;
      default: if (bus.redirect_ack_i) m_phase = 0;
    endcase
    @(negedge clk_i);
  endtask

  initial begin
    clear_inputs();
    #1;
    chk("rst_flush", 64'(bus.flush_o), 64'(5'b11111));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_valid", 64'(bus.trap_valid_o), 64'(0));
    chk("rst_cause", 64'(bus.trap_cause_o), 64'(0));
    chk("rst_pc", 64'(bus.trap_pc_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle();

    // stall back-pressure
    bus.stall_req_i = 5'b00100;
    #1;
    chk("bp_stall", 64'(bus.stall_o), 64'(5'b00111));
    chk("bp_flush", 64'(bus.flush_o), 64'(0));
    #1;
    cycle();
    clear_inputs();
    cycle();

    // branch flush drops wrong-path exception
    bus.flush_branch_i = 1'b1;
    bus.exc_valid_i = 5'b00001;
    #1;
    chk("br_flush", 64'(bus.flush_o), 64'(5'b00011));
    #1;
    cycle();
    clear_inputs();
    cycle();
    chk("br_busy", 64'(bus.busy_o), 64'(0));

    // exception priority: stage 3 beats stage 1
    bus.exc_valid_i = 5'b01010;
    bus.exc_cause_i[15:12] = 4'd4;
    bus.exc_cause_i[7:4]   = 4'd9;
    bus.exc_pc_i[XL*3 +: XL] = 32'h100;
    bus.exc_pc_i[XL*1 +: XL] = 32'h444;
    #1;
    chk("ex_flush", 64'(bus.flush_o), 64'(5'b01111));
    #1;
    cycle();
    clear_inputs();
    bus.redirect_ack_i = 1'b1;               // ack in TRAP is ignored
    chk("ex_valid", 64'(bus.trap_valid_o), 64'(1));
    chk("ex_cause", 64'(bus.trap_cause_o), 64'(5'h04));
    chk("ex_pc", 64'(bus.trap_pc_o), 64'(32'h100));
    cycle();
    bus.redirect_ack_i = 1'b0;
    bus.exc_valid_i = 5'b10000;              // ignored in WAIT
    cycle();
    bus.exc_valid_i = '0;
    chk("ex_wait_busy", 64'(bus.busy_o), 64'(1));
    bus.redirect_ack_i = 1'b1;
    cycle();
    bus.redirect_ack_i = 1'b0;
    chk("ex_idle_busy", 64'(bus.busy_o), 64'(0));
    cycle();

    // interrupt arbitration (only taken when the feature is built in)
    bus.irq_i = 3'b111;
    bus.irq_enable_i = 3'b011;
    bus.commit_pc_i = 32'h2000;
    cycle();
    clear_inputs();
    cycle();
    cycle();
    bus.redirect_ack_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();

    // reset while waiting for the redirect
    bus.exc_valid_i = 5'b10000;
    bus.exc_cause_i[19:16] = 4'd2;
    bus.exc_pc_i[XL*4 +: XL] = 32'hbeef;
    cycle();
    clear_inputs();
    cycle();
    cycle();
    chk("mr_busy_pre", 64'(bus.busy_o), 64'(1));
    rst_i = 1'b0;
    #1;
    chk("mr_busy", 64'(bus.busy_o), 64'(0));
    chk("mr_flush", 64'(bus.flush_o), 64'(5'b11111));
    chk("mr_valid", 64'(bus.trap_valid_o), 64'(0));
    m_phase = 0; m_cause = '0; m_pc = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.stall_req_i    = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      bus.flush_branch_i = ($urandom_range(4) == 0);
      bus.exc_valid_i    = ($urandom_range(2) == 0) ? N'($urandom) : '0;
      bus.exc_cause_i    = {$urandom, $urandom};
      for (int k = 0; k < N; k++) bus.exc_pc_i[XL*k +: XL] = $urandom;
      bus.irq_i          = 3'($urandom);
      bus.irq_enable_i   = 3'($urandom);
      bus.commit_pc_i    = $urandom;
      bus.redirect_ack_i = ($urandom_range(2) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
